// File: rtl/pll_lock_rst_ctrl_if.sv
// PLL-facing and system-facing signals of the PLL lock/reset supervisor.
// The master modport is the supervisor itself; slave is the PLL/system side.
interface pll_lock_rst_ctrl_if;
  logic       i_pll_lock;
  logic       o_pll_reset;
  logic       o_sys_rst;
  logic       o_ready;
  logic [7:0] o_lock_lost_cnt;
  logic [7:0] o_timeout_cnt;
  logic [1:0] o_state;

  modport master (
    input  i_pll_lock,
    output o_pll_reset, o_sys_rst, o_ready, o_lock_lost_cnt, o_timeout_cnt, o_state
  );

  modport slave (
    output i_pll_lock,
    input  o_pll_reset, o_sys_rst, o_ready, o_lock_lost_cnt, o_timeout_cnt, o_state
  );
endinterface

// File: rtl/pll_lock_rst_ctrl.sv
// PLL reset/lock supervisor on the reference clock: pulses PLL reset, waits for
// lock, requalifies it for STABLE_CYCLES, then releases the system reset.
module pll_lock_rst_ctrl #(
  parameter int unsigned STABLE_CYCLES  = 4096,
  parameter int unsigned LOCK_TIMEOUT   = 60000,
  parameter int unsigned PLL_RST_CYCLES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  pll_lock_rst_ctrl_if.master  bus
);

  localparam int unsigned MAX_A  = (STABLE_CYCLES > LOCK_TIMEOUT) ? STABLE_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MX = (MAX_A > PLL_RST_CYCLES) ? MAX_A : PLL_RST_CYCLES;
  localparam int unsigned CW     = (CNT_MX > 1) ? $clog2(CNT_MX) : 1;

  localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_sync1;
  logic          r_lock_s;
  logic          r_pll_reset;
  logic          r_sys_rst;
  logic          r_ready;
  logic [7:0]    r_lost_cnt;
  logic [7:0]    r_to_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= PLL_RST;
      r_cnt       <= '0;
      r_sync1     <= 1'b0;
      r_lock_s    <= 1'b0;
      r_pll_reset <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_lost_cnt  <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_sync1  <= bus.i_pll_lock;
      r_lock_s <= r_sync1;

      // Outputs are set alongside each transition so they change on the same edge.
      unique case (r_state)
        PLL_RST: begin
          if (r_cnt == PR_LAST) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_pll_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (r_lock_s) begin
            r_state <= STABILIZE;
            r_cnt   <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_state     <= PLL_RST;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            if (r_to_cnt != 8'hFF) r_to_cnt <= r_to_cnt + 8'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STABILIZE: begin
          if (!r_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == ST_LAST) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_sys_rst <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!r_lock_s) begin
            r_state     <= PLL_RST;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            if (r_lost_cnt != 8'hFF) r_lost_cnt <= r_lost_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= PLL_RST;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.o_pll_reset     = r_pll_reset;
  assign bus.o_sys_rst       = r_sys_rst;
  assign bus.o_ready         = r_ready;
  assign bus.o_lock_lost_cnt = r_lost_cnt;
  assign bus.o_timeout_cnt   = r_to_cnt;
  assign bus.o_state         = r_state;

endmodule

// File: tb/tb_pll_lock_rst_ctrl.sv
// Bench for pll_lock_rst_ctrl: directed scenarios plus random lock activity,
// checked each cycle against a phase/elapsed-time model of the supervisor.
module tb_pll_lock_rst_ctrl;
  localparam int ST = 8;
  localparam int TO = 100;
  localparam int PR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pll_lock_rst_ctrl_if bus();

  pll_lock_rst_ctrl #(
    .STABLE_CYCLES (ST),
    .LOCK_TIMEOUT  (TO),
    .PLL_RST_CYCLES(PR)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which phase we are in, how many edges spent there, and the lock
  // value as seen two edges late.
  int m_phase = 0;
  int m_elapsed = 0;
  int m_lost = 0;
  int m_to = 0;
  int m_s1 = 0;
  int m_ls = 0;

  always @(posedge clk) begin
    int seen;
    if (rst) begin
      m_phase = 0; m_elapsed = 0; m_lost = 0; m_to = 0; m_s1 = 0; m_ls = 0;
    end else begin
      seen = m_ls;
      m_ls = m_s1;
      m_s1 = int'(bus.i_pll_lock);
      m_elapsed++;
      case (m_phase)
        0: if (m_elapsed == PR) begin m_phase = 1; m_elapsed = 0; end
        1: if (seen == 1) begin m_phase = 2; m_elapsed = 0; end
           else if (m_elapsed == TO) begin
             m_to = (m_to < 255) ? m_to + 1 : 255;
             m_phase = 0; m_elapsed = 0;
           end
        2: if (seen == 0) begin m_phase = 1; m_elapsed = 0; end
           else if (m_elapsed == ST) begin m_phase = 3; m_elapsed = 0; end
        default: if (seen == 0) begin
             m_lost = (m_lost < 255) ? m_lost + 1 : 255;
             m_phase = 0; m_elapsed = 0;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state",     32'(bus.o_state),         32'(m_phase));
      check("pll_reset", 32'(bus.o_pll_reset),     32'(m_phase == 0));
      check("sys_rst",   32'(bus.o_sys_rst),       32'(m_phase != 3));
      check("ready",     32'(bus.o_ready),         32'(m_phase == 3));
      check("lost_cnt",  32'(bus.o_lock_lost_cnt), 32'(m_lost));
      check("to_cnt",    32'(bus.o_timeout_cnt),   32'(m_to));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.o_sys_rst;
      1:       return bus.o_pll_reset;
      default: return bus.o_ready;
    endcase
  endfunction

  // 0-based index of the first edge after which sig(sel)==val; -1 if never.
  task automatic edges_to(input int sel, input logic val, input int limit, output int idx);
    idx = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sig(sel) === val) begin
        idx = i;
        break;
      end
    end
  endtask

  task automatic pll_reset_width(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.o_pll_reset !== 1'b1) break;
      n++;
      tick(1);
    end
  endtask

  task automatic lose_recover();
    int idx;
    bus.i_pll_lock = 1'b0;
    tick(3);
    bus.i_pll_lock = 1'b1;
    edges_to(2, 1'b1, 60, idx);
    check("recover_run", 32'(idx >= 0), 32'd1);
  endtask

  initial begin
    int idx;
    int n;
    bus.i_pll_lock = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    check("rst_state", 32'(bus.o_state), 32'd0);
    check("rst_pll_reset", 32'(bus.o_pll_reset), 32'd1);
    check("rst_sys_rst", 32'(bus.o_sys_rst), 32'd1);
    check("rst_ready", 32'(bus.o_ready), 32'd0);
    check("rst_counts", 32'({bus.o_lock_lost_cnt, bus.o_timeout_cnt}), 32'd0);
    tick(2);

    // Power-up, lock arrives 10 cycles after reset release
    rst = 1'b0;
    pll_reset_width(n);
    check("pwrup_pll_reset_width", 32'(n), 32'd4);
    tick(6);
    bus.i_pll_lock = 1'b1;
    edges_to(0, 1'b0, 60, idx);
    check("pwrup_release_edge", 32'(idx), 32'd10);
    check("pwrup_ready", 32'(bus.o_ready), 32'd1);
    check("pwrup_state", 32'(bus.o_state), 32'd3);

    // Lock loss in RUN
    bus.i_pll_lock = 1'b0;
    edges_to(0, 1'b1, 20, idx);
    check("loss_edge", 32'(idx), 32'd2);
    check("loss_cnt", 32'(bus.o_lock_lost_cnt), 32'd1);
    pll_reset_width(n);
    check("loss_pll_reset_width", 32'(n), 32'd4);
    bus.i_pll_lock = 1'b1;
    edges_to(2, 1'b1, 60, idx);
    check("relock_edge", 32'(idx), 32'd10);

    // Glitch during STABILIZE: back to WAIT_LOCK, no PLL reset, no count
    bus.i_pll_lock = 1'b0;
    edges_to(1, 1'b1, 20, idx);
    edges_to(1, 1'b0, 20, idx);
    check("glitch_pre_lost", 32'(bus.o_lock_lost_cnt), 32'd2);
    bus.i_pll_lock = 1'b1;
    tick(5);
    bus.i_pll_lock = 1'b0;
    tick(3);
    check("glitch_state", 32'(bus.o_state), 32'd1);
    bus.i_pll_lock = 1'b1;
    edges_to(2, 1'b1, 60, idx);
    check("glitch_requal_edge", 32'(idx), 32'd10);
    check("glitch_lost", 32'(bus.o_lock_lost_cnt), 32'd2);
    check("glitch_to", 32'(bus.o_timeout_cnt), 32'd0);

    // Reset mid-RUN with three recorded losses
    lose_recover();
    check("mid_lost3", 32'(bus.o_lock_lost_cnt), 32'd3);
    rst = 1'b1;
    tick(1);
    check("mid_state", 32'(bus.o_state), 32'd0);
    check("mid_sys_rst", 32'(bus.o_sys_rst), 32'd1);
    check("mid_pll_reset", 32'(bus.o_pll_reset), 32'd1);
    check("mid_counts", 32'({bus.o_lock_lost_cnt, bus.o_timeout_cnt}), 32'd0);
    rst = 1'b0;

    // Random lock activity with occasional resets
    for (int seg = 0; seg < 200; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      bus.i_pll_lock = ($urandom_range(0, 3) != 0);
      tick(int'($urandom_range(1, 40)));
    end

    // Never lock: timeout every 104 cycles, saturating at 255
    bus.i_pll_lock = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(104);
    check("to_1", 32'(bus.o_timeout_cnt), 32'd1);
    tick(104);
    check("to_2", 32'(bus.o_timeout_cnt), 32'd2);
    tick(104);
    check("to_3", 32'(bus.o_timeout_cnt), 32'd3);
    tick(104 * 252);
    check("to_255", 32'(bus.o_timeout_cnt), 32'd255);
    tick(104 * 2);
    check("to_sat", 32'(bus.o_timeout_cnt), 32'd255);
    check("to_sys_rst", 32'(bus.o_sys_rst), 32'd1);

    // 256+ lock losses: lock_lost_cnt saturates
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.i_pll_lock = 1'b1;
    edges_to(2, 1'b1, 60, idx);
    check("sat_first_run", 32'(idx >= 0), 32'd1);
    for (int k = 0; k < 257; k++) lose_recover();
    check("lost_sat", 32'(bus.o_lock_lost_cnt), 32'd255);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pll_lock_rst_ctrl.md
# pll_lock_rst_ctrl

Reset and lock supervisor that sits directly downstream of the rPLL wrapper: it consumes the PLL `lock` flag and drives the PLL `RESET` input. It runs on the 12 MHz reference clock that also feeds the PLL `clkin`, so it keeps working when the PLL output is absent. It produces a clean active-high system reset for the USB logic, which stays asserted until lock has been continuously stable. Lock loss and lock timeouts force a PLL re-reset and are counted.

## Interface
- `STABLE_CYCLES`, default 4096: consecutive synchronized-lock cycles required before releasing `sys_rst` (≥1).
- `LOCK_TIMEOUT`, default 60000: cycles allowed in WAIT_LOCK before forcing a PLL re-reset (≥1).
- `PLL_RST_CYCLES`, default 16: cycles `pll_reset` is held high per reset pulse (≥1).
- `clk  in  1`: 12 MHz reference clock, same net as PLL `clkin`.
- `reset  in  1`: synchronous, active-high block reset.
- `pll_lock  in  1`: PLL `lock` output; asynchronous to `clk`.
- `pll_reset  out  1`: drives PLL `RESET`; registered, active-high.
- `sys_rst  out  1`: active-high reset to downstream logic; registered, in the `clk` domain (consumers resynchronize).
- `ready  out  1`: high only in RUN; the registered complement of `sys_rst`.
- `lock_lost_cnt  out  8`: saturating count of lock losses seen in RUN.
- `timeout_cnt  out  8`: saturating count of WAIT_LOCK timeouts.
- `state  out  2`: current state encoding: PLL_RST=0, WAIT_LOCK=1, STABILIZE=2, RUN=3.

## Operation
- A 2-FF synchronizer on `pll_lock` produces `lock_s`. The FSM uses only `lock_s`.
- There is one shared cycle counter `cnt`, sized to hold max(STABLE_CYCLES, LOCK_TIMEOUT, PLL_RST_CYCLES). It clears to 0 on every state transition.
- PLL_RST:
  - Outputs: `pll_reset`=1, `sys_rst`=1, `ready`=0.
  - `cnt` increments each cycle.
  - When `cnt`==PLL_RST_CYCLES-1, the next state is WAIT_LOCK.
- WAIT_LOCK:
  - Outputs: `pll_reset`=0, `sys_rst`=1.
  - If `lock_s`=1, go to STABILIZE.
  - Otherwise, if `cnt`==LOCK_TIMEOUT-1, go to PLL_RST and increment `timeout_cnt` (saturates at 255).
- STABILIZE:
  - Outputs: `sys_rst`=1.
  - If `lock_s`=0, go to WAIT_LOCK. There is no PLL reset and no count increment.
  - If `lock_s`=1 and `cnt`==STABLE_CYCLES-1, go to RUN.
- RUN:
  - Outputs: `sys_rst`=0, `ready`=1.
  - If `lock_s`=0, go to PLL_RST and increment `lock_lost_cnt` (saturates at 255).
- All outputs are registered and are updated on the same edge as the state transition that sets them.
- Reset values (also re-applied by `reset` at any time, mid-operation included):
  - State = PLL_RST, `cnt`=0.
  - `pll_reset`=1, `sys_rst`=1, `ready`=0.
  - Both event counters = 0.
  - Synchronizer flops = 0.
- Counter saturation: at 255 an event leaves the count unchanged. There is no wrap.

## Timing
- The counts below refer to `clk` rising edges, with edge 0 being the first edge after the `pll_lock` change.
- Release latency, case WAIT_LOCK when `pll_lock` rises:
  - Edge 0: sync FF1=1. Edge 1: `lock_s`=1. Edge 2: enter STABILIZE.
  - `sys_rst`=0 and `ready`=1 after edge STABLE_CYCLES+2.
- Loss latency, case RUN when `pll_lock` falls:
  - Edge 2: `sys_rst`=1, `ready`=0, state PLL_RST, `lock_lost_cnt`+1.
  - `pll_reset` is high from edge 2 to edge 2+PLL_RST_CYCLES (exclusive).
- After `reset` deasserts, `pll_reset` stays high for exactly PLL_RST_CYCLES cycles.
- Lock glitches shorter than one `clk` period may be missed. That is acceptable, because lock is also re-qualified in STABILIZE.
- Simultaneous events:
  - `reset`=1 overrides every FSM transition and counter increment in the same cycle.
  - In WAIT_LOCK, `lock_s`=1 on the timeout cycle means STABILIZE wins, with no timeout counted.

## Test plan
- Power-up with STABLE=8, TIMEOUT=100, PLL_RST=4, `pll_lock` rising 10 cycles after `reset` falls:
  - `pll_reset` is high for 4 cycles.
  - `sys_rst` falls exactly 8+2 edges after `pll_lock` rises.
  - `ready`=1 and `state`=3.
- Lock loss in RUN:
  - Drop `pll_lock` → `sys_rst`=1 at edge 2, `lock_lost_cnt`=1.
  - `pll_reset` pulses for 4 cycles.
  - `pll_lock` returning gives RUN again after 10 edges.
- Never lock, TIMEOUT=100:
  - `timeout_cnt` increments every 104 cycles (100 WAIT_LOCK + 4 PLL_RST).
  - `sys_rst` is never released.
  - Saturates at 255 after 255 timeouts.
- Glitch in STABILIZE: drop `pll_lock` for 3 cycles at STABILIZE `cnt`=5:
  - The block returns to WAIT_LOCK.
  - No `pll_reset` pulse and no count change.
  - Full 8-cycle requalification before release.
- Reset mid-RUN with `lock_lost_cnt`=3:
  - Assert `reset` for 1 cycle → next edge gives `state`=0, `sys_rst`=1, `pll_reset`=1, both counts 0.
- Saturation: force 256 lock losses → `lock_lost_cnt` stays at 255 and still no wrap.
